// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp fetch/decode path: fetch FSM states and
// the opcode values that both fetch and ctrl_module decoding rely on.
package mpp_pkg;

    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    localparam logic [7:0] NOP_OP  = 8'h00;
    localparam logic [7:0] HALT_OP = 8'hFF;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with flush; entry 0 is always the head, so the consumer
// sees registered data with no read-pointer mux.
module fetch_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    // Qualify requests so an empty pop or a full push can never corrupt state
    always_comb begin
        w_pop  = i_pop && (r_count != 2'd0);
        w_push = i_push && ((r_count != 2'd2) || w_pop);
    end

    // Storage and occupancy; flush wins over any push/pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0    <= {W{1'b0}};
            r_e1    <= {W{1'b0}};
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= i_data;
                    else                 r_e1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_e0 <= i_data;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_data;
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_e0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: prefetches program bytes from synchronous
// memory into a 2-entry buffer and hands them to ctrl_module over valid/ready.
module instr_fetch
    import mpp_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] HALT_OPCODE = HALT_OP,
    parameter logic [7:0] NOP_OPCODE  = NOP_OP
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
);

    localparam int ENTRY_W = 8 + ADDR_W;

    fetch_state_e        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_inflight;

    logic [1:0]          w_count;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_run;
    logic                w_valid;
    logic                w_pop;
    logic                w_halt_pop;
    logic                w_issue;
    logic                w_push;
    logic                w_flush;
    logic [2:0]          w_occ;

    // Handshake, issue and flush decisions for the current cycle
    always_comb begin
        w_run      = (r_state == FETCH_RUN);
        w_valid    = w_run && (w_count != 2'd0) && !redirect_en;
        w_pop      = w_valid && instr_ready;
        w_halt_pop = w_pop && (w_head[ENTRY_W-1 -: 8] == HALT_OPCODE);
        w_occ      = {1'b0, w_count} + {2'b00, r_inflight};
        // rst_n gating keeps the strobe low while reset is held
        w_issue    = rst_n && w_run && !redirect_en &&
                     (w_occ < (3'd2 + {2'b00, w_pop}));
        w_push     = w_run && r_inflight && !redirect_en && !w_halt_pop;
        w_flush    = redirect_en || w_halt_pop;
    end

    fetch_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({mem_rdata, r_rd_addr}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // PC, in-flight tracking and RUN/HALTED state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH_RUN;
            r_pc       <= {ADDR_W{1'b0}};
            r_rd_addr  <= {ADDR_W{1'b0}};
            r_inflight <= 1'b0;
        end else if (redirect_en) begin
            r_state    <= FETCH_RUN;
            r_pc       <= redirect_addr;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                FETCH_RUN: begin
                    if (w_issue) begin
                        r_pc      <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_rd_addr <= r_pc;
                    end
                    // a read issued alongside the halt pop is abandoned
                    r_inflight <= w_issue && !w_halt_pop;
                    if (w_halt_pop) r_state <= FETCH_HALTED;
                end
                FETCH_HALTED: r_inflight <= 1'b0;
                default: begin
                    r_state    <= FETCH_RUN;
                    r_inflight <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en   = w_issue;
    assign mem_addr    = r_pc;
    assign instr_valid = w_valid;
    assign instr_out   = (w_count != 2'd0) ? w_head[ENTRY_W-1 -: 8] : NOP_OPCODE;
    assign instr_pc    = (w_count != 2'd0) ? w_head[ADDR_W-1:0] : {ADDR_W{1'b0}};
    assign halted      = (r_state == FETCH_HALTED);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch/issue unit. Drives the 8-bit instruction byte into the control decoder (ctrl_module) inside mpp.
- Reads program bytes from a synchronous program memory, buffers up to two prefetched bytes, and presents them over a valid/ready handshake.
- Supports redirect (jump/branch) from the datapath, and a halt opcode that stops fetching.

Parameters:
- ADDR_W, 8, program-counter and memory address width.
- HALT_OPCODE, 8'hFF, opcode that halts fetch once consumed.
- NOP_OPCODE, 8'h00, value driven on instr_out when no valid instruction.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd_en  out  1  program memory read strobe.
- mem_addr  out  ADDR_W  program memory read address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- instr_out  out  8  instruction byte to ctrl_module.
- instr_pc  out  ADDR_W  address of instr_out.
- instr_valid  out  1  instr_out is valid.
- instr_ready  in  1  consumer accepts instr_out this cycle.
- redirect_en  in  1  single-cycle pulse; jump to redirect_addr.
- redirect_addr  in  ADDR_W  jump target.
- halted  out  1  high while in HALTED.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc=0, state=RUN, buffer empty, in-flight flag=0.
  - Outputs: mem_rd_en=0, mem_addr=0, instr_valid=0, instr_out=NOP_OPCODE, instr_pc=0, halted=0.
  - Reset mid-operation discards all buffered and in-flight data immediately.
- Buffer:
  - 2-entry FIFO of {byte, addr}; count 0..2.
  - instr_valid = (count!=0) && state==RUN.
  - instr_out/instr_pc = head entry, or NOP_OPCODE/0 when empty.
  - Pop when instr_valid && instr_ready.
- Read issue (RUN only):
  - mem_rd_en=1 when count + inflight − pop < 2, where pop is this cycle's pop.
  - On issue: mem_addr=pc, pc<=pc+1 (wraps 2^ADDR_W−1 -> 0), inflight<=1.
  - Next cycle: mem_rdata is pushed with its address; simultaneous push and pop is allowed.
  - Throughput: 1 instruction/cycle with instr_ready held high.
  - First instruction after reset: mem_rd_en in cycle 1 after reset release, instr_valid in cycle 2.
- Redirect (priority over everything):
  - Flush FIFO; drop the in-flight response (its mem_rdata is ignored next cycle); pc<=redirect_addr; no read issued in the redirect cycle.
  - Any pop in that same cycle is void: instr_valid forced 0 that cycle.
  - First read of redirect_addr occurs the next cycle.
- States:
  - RUN: normal operation. On a pop whose byte == HALT_OPCODE -> HALTED: flush FIFO, drop in-flight, stop reads. The halt byte itself is delivered; pc is left pointing past the last issued read.
  - HALTED: halted=1, instr_valid=0, mem_rd_en=0. redirect_en -> RUN at redirect_addr. Other inputs are ignored.
  - redirect_en in the same cycle as a HALT pop: redirect wins; state stays RUN.
- Boundaries:
  - instr_ready high while empty: no effect.
  - FIFO full with ready low: no reads issued; pc holds.
  - FIFO is never overwritten: the issue rule guarantees no push into a full buffer.

Decomposition:
- Shared package mpp_pkg holds:
  - fetch state enum {FETCH_RUN, FETCH_HALTED}.
  - NOP and HALT opcode constants, also used by ctrl_module decoding.
- One natural sub-module: fetch_fifo, a 2-entry FIFO (push, pop, flush, count, head) parameterised on entry width.
- Issue logic, pc and FSM stay in instr_fetch.

Test Plan:
- Reset release, memory holds 0x10,0x11,0x12 at 0..2, ready=1 -> mem_addr 0,1,2 on consecutive cycles; instr_out 0x10,0x11,0x12 with instr_pc 0,1,2, one per cycle from cycle 2.
- ready=0 for 5 cycles -> exactly 2 reads issued, count=2, mem_rd_en=0; ready=1 -> bytes delivered in order, none lost or duplicated.
- Redirect to 0x40 while an addr-3 read is in flight -> addr-3 data never appears; next instr_out is mem[0x40] with instr_pc 0x40.
- mem[5]=0xFF: byte 0xFF delivered with instr_pc 5; next cycle halted=1, instr_valid=0, mem_rd_en=0 held 10 cycles; redirect_en to 0x00 -> halted=0 and fetch resumes at 0.
- pc at 0xFE, continuous ready -> fetch addresses 0xFE, 0xFF, 0x00, 0x01.
- rst_n asserted mid-stream with count=2 -> instr_valid=0, mem_rd_en=0 immediately; after release fetch restarts at addr 0.
